// File: rtl/ct_ifu_btb_tag_ctrl.sv
// ct_ifu_btb_tag_ctrl
// Access controller for the IFU BTB tag SRAM. It arbitrates single-cycle IF
// lookups against a 2-entry buffer of tag updates. It also runs a full-array
// invalidate sweep after reset and on cp0 request.
// Optional macro CT_BTB_TAG_STARVE_GUARD_EN: after four reads win over a
// pending write, the next cycle is forced to write. Without the macro, reads
// always win.
module ct_ifu_btb_tag_ctrl (
   input  logic        forever_cpuclk,
   input  logic        cpurst,
   input  logic        cp0_ifu_btb_inv,
   output logic        btb_inv_busy,
   input  logic        lookup_vld,
   input  logic [8:0]  lookup_index,
   output logic        lookup_gnt,
   output logic        btb_tag_rd_vld,
   input  logic        upd_vld,
   input  logic [8:0]  upd_index,
   input  logic [1:0]  upd_way,
   input  logic [10:0] upd_tag,
   output logic        upd_rdy,
   output logic [9:0]  btb_index,
   output logic        btb_tag_cen_b,
   output logic        btb_tag_clk_en,
   output logic [21:0] btb_tag_din,
   output logic [3:0]  btb_tag_wen
);

   typedef enum logic {ST_INV, ST_RUN} state_t;

   typedef struct packed {
      logic [8:0]  index;
      logic [1:0]  way;
      logic [10:0] tag;
   } wb_entry_t;

   state_t      state_q, state_d;
   logic [8:0]  cnt_q, cnt_d;
   wb_entry_t   wb_q [2];
   logic        wr_ptr_q, rd_ptr_q;
   logic [1:0]  occ_q, occ_d;
   logic        upd_rdy_q, upd_rdy_d;
   logic        rd_vld_q;
   logic        run, wb_nempty, force_wr, rd_gnt, wr_go, push;
   wb_entry_t   head;

   assign run       = (state_q == ST_RUN);
   assign wb_nempty = (occ_q != 2'd0);
   assign head      = wb_q[rd_ptr_q];

`ifdef CT_BTB_TAG_STARVE_GUARD_EN
   logic [2:0] starve_q;

   // Count reads that win while a write is waiting. Any write clears the count.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst || !run || cp0_ifu_btb_inv)
         starve_q <= 3'd0;
      else if (wr_go)
         starve_q <= 3'd0;
      else if (rd_gnt && wb_nempty && starve_q != 3'd7)
         starve_q <= starve_q + 3'd1;
   end

   assign force_wr = wb_nempty && (starve_q == 3'd4);
`else
   assign force_wr = 1'b0;
`endif

   assign rd_gnt = run && lookup_vld && !force_wr;
   assign wr_go  = run && !rd_gnt && wb_nempty;
   assign push   = upd_vld && upd_rdy_q;

   // Next state: an inv pulse always restarts the sweep at 0 and flushes the buffer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (cp0_ifu_btb_inv) begin
         state_d = ST_INV;
         cnt_d   = 9'd0;
      end else if (state_q == ST_INV) begin
         cnt_d = cnt_q + 9'd1;
         if (cnt_q == 9'd511) state_d = ST_RUN;
      end
      occ_d = cp0_ifu_btb_inv ? 2'd0 : (occ_q + 2'(push) - 2'(wr_go));
      // upd_rdy is registered, so compute it from next-cycle occupancy.
      upd_rdy_d = (state_d == ST_RUN) && (occ_d < 2'd2);
   end

   // Control state: FSM, sweep counter, buffer pointers, registered handshakes.
   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state_q   <= ST_INV;
         cnt_q     <= 9'd0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         occ_q     <= 2'd0;
         upd_rdy_q <= 1'b0;
         rd_vld_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         occ_q     <= occ_d;
         upd_rdy_q <= upd_rdy_d;
         rd_vld_q  <= rd_gnt;
         if (cp0_ifu_btb_inv) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
         end else begin
            if (push)  wr_ptr_q <= ~wr_ptr_q;
            if (wr_go) rd_ptr_q <= ~rd_ptr_q;
         end
      end
   end

   // Buffer payload storage. Occupancy and pointers qualify it, so it needs no reset.
   always_ff @(posedge forever_cpuclk) begin
      if (push) wb_q[wr_ptr_q] <= '{index: upd_index, way: upd_way, tag: upd_tag};
   end

   // Array drive: sweep write, lookup read, buffered write, or idle.
   always_comb begin
      btb_index     = 10'd0;
      btb_tag_cen_b = 1'b1;
      btb_tag_wen   = 4'hf;
      btb_tag_din   = 22'd0;
      if (!run) begin
         btb_index     = {1'b0, cnt_q};
         btb_tag_cen_b = 1'b0;
         btb_tag_wen   = 4'h0;
      end else if (rd_gnt) begin
         btb_index     = {1'b0, lookup_index};
         btb_tag_cen_b = 1'b0;
      end else if (wr_go) begin
         btb_index     = {1'b0, head.index};
         btb_tag_cen_b = 1'b0;
         btb_tag_wen   = ~(4'b0001 << head.way);
         btb_tag_din   = {head.tag, head.tag};
      end
   end

   assign btb_tag_clk_en = !btb_tag_cen_b;
   assign lookup_gnt     = rd_gnt;
   assign btb_tag_rd_vld = rd_vld_q;
   assign upd_rdy        = upd_rdy_q;
   assign btb_inv_busy   = !run;

endmodule

// File: tb/tb_ct_ifu_btb_tag_ctrl.sv
// Directed bench for ct_ifu_btb_tag_ctrl. It covers the reset sweep, writes,
// arbitration, the starve guard (when the macro is defined), inv flush and
// sweep restart.
module tb_ct_ifu_btb_tag_ctrl;

   logic        clk = 1'b0;
   logic        cpurst, inv, busy;
   logic        lookup_vld, lookup_gnt, rd_vld;
   logic [8:0]  lookup_index;
   logic        upd_vld, upd_rdy;
   logic [8:0]  upd_index;
   logic [1:0]  upd_way;
   logic [10:0] upd_tag;
   logic [9:0]  btb_index;
   logic        cen_b, clk_en;
   logic [21:0] din;
   logic [3:0]  wen;

   int checks = 0;
   int errors = 0;

   ct_ifu_btb_tag_ctrl dut (
      .forever_cpuclk (clk),
      .cpurst         (cpurst),
      .cp0_ifu_btb_inv(inv),
      .btb_inv_busy   (busy),
      .lookup_vld     (lookup_vld),
      .lookup_index   (lookup_index),
      .lookup_gnt     (lookup_gnt),
      .btb_tag_rd_vld (rd_vld),
      .upd_vld        (upd_vld),
      .upd_index      (upd_index),
      .upd_way        (upd_way),
      .upd_tag        (upd_tag),
      .upd_rdy        (upd_rdy),
      .btb_index      (btb_index),
      .btb_tag_cen_b  (cen_b),
      .btb_tag_clk_en (clk_en),
      .btb_tag_din    (din),
      .btb_tag_wen    (wen)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Step past the next rising edge. Inputs change here; outputs are checked #1 later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check n sweep cycles starting at index 0. Lookups are held high to show they are blocked.
   task automatic sweep(input string tag, input int n);
      lookup_vld   = 1'b1;
      lookup_index = 9'h1ff;
      for (int i = 0; i < n; i++) begin
         #1;
         chk(tag, {busy, cen_b, clk_en, wen, btb_index, din, lookup_gnt, upd_rdy},
                  {1'b1, 1'b0, 1'b1, 4'h0, 10'(i), 22'h0, 1'b0, 1'b0});
         tick();
      end
      lookup_vld = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk(tag, {cen_b, clk_en, wen, lookup_gnt}, {1'b1, 1'b0, 4'hf, 1'b0});
   endtask

   initial begin
      cpurst = 1'b1; inv = 1'b0; lookup_vld = 1'b0; lookup_index = '0;
      upd_vld = 1'b0; upd_index = '0; upd_way = '0; upd_tag = '0;

      // Reset state
      tick(); tick(); tick();
      #1;
      chk("rst_regs",  {busy, rd_vld, upd_rdy}, {1'b1, 1'b0, 1'b0});
      chk("rst_array", {cen_b, clk_en, wen, btb_index, din}, {1'b0, 1'b1, 4'h0, 10'h0, 22'h0});
      cpurst = 1'b0;

      // Full sweep after reset, then RUN
      sweep("rst_sweep", 512);
      #1;
      chk("sweep_done", {busy, upd_rdy}, {1'b0, 1'b1});
      chk_idle("run_idle");

      // Single update with no lookups
      upd_vld = 1'b1; upd_index = 9'h005; upd_way = 2'd2; upd_tag = 11'h3a5;
      #1;
      chk("upd_accept_idle", {cen_b, upd_rdy}, {1'b1, 1'b1});
      tick(); upd_vld = 1'b0;
      #1;
      chk("upd_write", {cen_b, clk_en, wen, btb_index, din},
                       {1'b0, 1'b1, 4'b1011, 10'h005, 22'h1d2ba5});
      tick(); #1;
      chk_idle("post_write_idle");

      // Lookup and update in the same cycle with an empty buffer: the read wins
      lookup_vld = 1'b1; lookup_index = 9'h1ab;
      upd_vld = 1'b1; upd_index = 9'h00c; upd_way = 2'd3; upd_tag = 11'h7ff;
      #1;
      chk("rd_vs_upd_gnt", {lookup_gnt, cen_b, wen, btb_index}, {1'b1, 1'b0, 4'hf, 10'h1ab});
      tick(); lookup_vld = 1'b0; upd_vld = 1'b0;
      #1;
      chk("rd_vld_next",  rd_vld, 1'b1);
      chk("deferred_write", {lookup_gnt, cen_b, wen, btb_index, din},
                            {1'b0, 1'b0, 4'b0111, 10'h00c, 22'h3fffff});
      tick(); #1;
      chk("rd_vld_clear", rd_vld, 1'b0);
      chk_idle("idle_after_deferred");

      // Fill the buffer under continuous lookups
      lookup_vld = 1'b1; lookup_index = 9'h010;
      upd_vld = 1'b1; upd_index = 9'h021; upd_way = 2'd0; upd_tag = 11'h111;
      tick();
      upd_index = 9'h022; upd_way = 2'd1; upd_tag = 11'h222;
      #1;
      chk("fill_gnt", {lookup_gnt, rd_vld, upd_rdy}, {1'b1, 1'b1, 1'b1});
      tick();
      upd_index = 9'h033; upd_way = 2'd3; upd_tag = 11'h333;
      #1;
      chk("full_rdy", upd_rdy, 1'b0);
      for (int k = 0; k < 6; k++) begin
         logic       eg, ev;
         logic [3:0] ew;
         logic [9:0] ei;
         eg = 1'b1; ev = 1'b1; ew = 4'hf; ei = 10'h010;
`ifdef CT_BTB_TAG_STARVE_GUARD_EN
         if (k == 3) begin eg = 1'b0; ew = 4'b1110; ei = 10'h021; end
         if (k == 4) ev = 1'b0;
`endif
         if (k > 0) #1;
         chk("starve", {lookup_gnt, rd_vld, cen_b, wen, btb_index}, {eg, ev, 1'b0, ew, ei});
         tick();
         upd_vld = 1'b0;
      end

      // inv with buffered entries: flush, restart sweep, then inv again at index 300
      inv = 1'b1;
      tick(); inv = 1'b0;
      #1;
      chk("inv_enter", {busy, upd_rdy, lookup_gnt, btb_index}, {1'b1, 1'b0, 1'b0, 10'h0});
      sweep("inv_sweep_a", 300);
      inv = 1'b1;
      #1;
      chk("inv_at_300", {btb_index, wen}, {10'd300, 4'h0});
      tick(); inv = 1'b0;
      sweep("inv_sweep_b", 512);
      #1;
      chk("inv_done", {busy, upd_rdy}, {1'b0, 1'b1});
      chk_idle("flushed_idle");
      tick(); #1;
      chk_idle("flushed_idle2");

      // cpurst in the middle of a sweep
      inv = 1'b1;
      tick(); inv = 1'b0;
      sweep("rst_mid_a", 300);
      cpurst = 1'b1;
      tick(); cpurst = 1'b0;
      #1;
      chk("rst_mid_regs", {rd_vld, upd_rdy}, {1'b0, 1'b0});
      sweep("rst_mid_b", 512);
      #1;
      chk("rst_mid_done", {busy, upd_rdy}, {1'b0, 1'b1});
      chk_idle("final_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
